mac_rr_sched: RTL
=================

// Module: mac_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one mac_top multiplier among NREQ requesters.
//  Accepts per-requester A/W operand beats with signedness flags over valid/ready.
//  Issues one beat per cycle to the multiplier and returns Q to the owning requester.
//  Honours req_last so a multi-beat operand vector (dot product) is issued atomically.
// PARAMETERS
//  DW       8  operand width; product width is 2*DW+1
//  NREQ     4  number of requesters, >=2
//  MUL_LAT  2  cycles from mul_a/mul_w valid at mac_top input to mul_q valid
// PORTS
//  clk          in   1           clock, all logic on posedge
//  rst          in   1           asynchronous, active-high reset
//  req_valid    in   NREQ        per-requester beat valid
//  req_ready    out  NREQ        per-requester accept; at most one bit high
//  req_a        in   NREQ*DW     operand A, requester i at [i*DW +: DW]
//  req_w        in   NREQ*DW     operand W, same packing
//  req_asigned  in   NREQ        A is signed
//  req_wsigned  in   NREQ        W is signed
//  req_last     in   NREQ        beat closes requester's locked sequence
//  mul_a        out  DW          to mac_top A (registered)
//  mul_w        out  DW          to mac_top W (registered)
//  mul_asigned  out  1           to mac_top Asigned (registered)
//  mul_wsigned  out  1           to mac_top Wsigned (registered)
//  mul_q        in   2*DW+1      from mac_top Q
//  rsp_valid    out  NREQ        one-hot response strobe, no backpressure
//  rsp_q        out  2*DW+1      response product, valid with rsp_valid
//  busy         out  1           any beat in flight or lock held
// BEHAVIOUR
//  Reset: req_ready=0, mul_*=0, rsp_valid=0, rsp_q=0, busy=0, state=IDLE, rr_ptr=0.
//  In flight: all in-flight beats are dropped, and no rsp_valid is produced for them.
//  FSM IDLE: grant the first valid requester at or after rr_ptr (wrapping).
//   Only the granted requester's req_ready is high, combinationally from req_valid.
//   A handshake with req_last=1 stays in IDLE, and rr_ptr moves to grant+1 mod NREQ.
//   A handshake with req_last=0 goes to LOCKED(owner=grant).
//  FSM LOCKED: req_ready[owner]=1; every other requester gets req_ready=0.
//   A cycle with owner req_valid=0 is a bubble, and the lock is held.
//   A handshake with req_last=1 goes to IDLE, and rr_ptr moves to owner+1 mod NREQ.
//  Handshake at cycle t: mul_* are loaded at t+1 from the granted lane.
//   With no handshake, mul_a and mul_w are driven to 0 and the flags hold their value.
//  Tag pipe: shift register of depth MUL_LAT+1 holding {vld, id[$clog2(NREQ)-1:0]}.
//   Entry is made at t, and the entry aligns with mul_q valid at t+1+MUL_LAT.
//   rsp_valid[id] and rsp_q<=mul_q are registered and appear at t+2+MUL_LAT.
//   Total latency is MUL_LAT+2 (4 at the default).
//  Throughput: one beat per cycle, back-to-back across requesters with no idle cycle.
//  Width: rsp_q is the raw 2*DW+1 mac_top output. No truncation or accumulation here.
//  Simultaneous: a handshake with last=1 and a new grant cannot happen in the same cycle.
//   The next requester is granted from the following cycle.
//  busy = state==LOCKED | any tag-pipe vld | any rsp_valid.
// STRUCTURE
//  mac_pkg: localparam QW=2*DW+1; typedef enum logic {IDLE, LOCKED} sched_state_e;
//   typedef struct packed {logic vld; logic [IDW-1:0] id;} mac_tag_t.
//  Sub-module rr_arbiter #(NREQ): req vector + ptr -> one-hot grant, combinational.
//  The FSM, operand mux, tag pipe and response register stay in mac_rr_sched.
// TESTING (DW=8, NREQ=4, MUL_LAT=2, mac_top instantiated behind the scheduler)
//  1 Req0 sends one beat A=-3, W=5, both signed, last=1 at cycle t.
//    -> rsp_valid=4'b0001 at t+4 with rsp_q=-15; busy drops the cycle after.
//  2 All four requesters valid with last=1 and rr_ptr=0.
//    -> grants go 0,1,2,3 on consecutive cycles; responses come back 0,1,2,3 on t+4..t+7.
//  3 Req2 sends a 3-beat lock (last on beat 3); req1 is valid the whole time.
//    -> req1 is granted only after req2's last beat; rr_ptr=3, so req3 wins ties next.
//  4 Locked owner drops valid for 2 cycles mid-sequence.
//    -> no other grant; mul_a=0 and mul_w=0 during the bubbles; response order is preserved.
//  5 Unsigned 255*255 and signed -128*-128.
//    -> rsp_q = 65025 and 16384 respectively, full 17-bit values.
//  6 rst pulsed for one cycle with 3 beats in flight and the FSM LOCKED.
//    -> no rsp_valid afterwards, state=IDLE, req_ready=0 during reset, rr_ptr=0.
//  Continuously check: $onehot0(req_ready), $onehot0(rsp_valid), and responses per id equal beats issued, in order.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types for the round-robin multiplier scheduler.
// Holds default sizing, FSM state encoding and the tag-pipe entry layout.
// Requester ids are carried at a fixed width so the tag type is parameter-free.
package mac_pkg;

  localparam int DW_DFLT      = 8;
  localparam int NREQ_DFLT    = 4;
  localparam int MUL_LAT_DFLT = 2;

  // Tag ids are sized for the largest supported requester count (16).
  localparam int NREQ_MAX = 16;
  localparam int IDW      = $clog2(NREQ_MAX);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } mac_tag_t;

  // Round-robin successor of a requester id, wrapping at nreq.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id, input int nreq);
    if (int'(id) >= nreq - 1) begin
      return '0;
    end
    return id + IDW'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is at most one-hot and zero when no request is set.
module rr_arbiter
  import mac_pkg::*;
#(
  parameter int NREQ = NREQ_DFLT
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt
);

  // Scan from ptr upwards, first hit wins.
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_rr_sched.sv
// Round-robin scheduler sharing one multiplier among NREQ requesters, with lockable multi-beat sequences.
// Latency: handshake to rsp_valid is MUL_LAT+2 cycles; one beat per cycle throughput.
// Backpressure: req_ready is granted to at most one requester; responses have no backpressure.
module mac_rr_sched
  import mac_pkg::*;
#(
  parameter  int DW      = DW_DFLT,
  parameter  int NREQ    = NREQ_DFLT,
  parameter  int MUL_LAT = MUL_LAT_DFLT,
  localparam int QW      = 2 * DW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_w,
  input  logic [NREQ-1:0]      req_asigned,
  input  logic [NREQ-1:0]      req_wsigned,
  input  logic [NREQ-1:0]      req_last,
  output logic [DW-1:0]        mul_a,
  output logic [DW-1:0]        mul_w,
  output logic                 mul_asigned,
  output logic                 mul_wsigned,
  input  logic [QW-1:0]        mul_q,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [QW-1:0]        rsp_q,
  output logic                 busy
);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic [DW-1:0]  mul_a_q, mul_a_d;
  logic [DW-1:0]  mul_w_q, mul_w_d;
  logic           mul_as_q, mul_as_d;
  logic           mul_ws_q, mul_ws_d;

  mac_tag_t       tag_q [MUL_LAT+1];
  mac_tag_t       tag_d [MUL_LAT+1];

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [QW-1:0]   rsp_q_q, rsp_q_d;

  logic [NREQ-1:0] arb_gnt;
  logic [NREQ-1:0] sel_oh;
  logic            hs;
  logic [IDW-1:0]  sel_id;
  logic [DW-1:0]   sel_a, sel_w;
  logic            sel_as, sel_ws, sel_last;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  // Lane selection: arbiter winner when idle, the lock owner (valid or not) when locked.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (state_q == IDLE) begin
        sel_oh[i] = arb_gnt[i];
      end else begin
        sel_oh[i] = (owner_q == IDW'(i));
      end
    end
    // Nothing is accepted while reset is asserted.
    req_ready = rst ? '0 : sel_oh;
    hs        = |(req_ready & req_valid);
  end

  // Operand mux from the selected lane.
  always_comb begin
    sel_id   = '0;
    sel_a    = '0;
    sel_w    = '0;
    sel_as   = 1'b0;
    sel_ws   = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_oh[i]) begin
        sel_id   = IDW'(i);
        sel_a    = req_a[i*DW +: DW];
        sel_w    = req_w[i*DW +: DW];
        sel_as   = req_asigned[i];
        sel_ws   = req_wsigned[i];
        sel_last = req_last[i];
      end
    end
  end

  // Scheduler FSM: a beat without last locks the grant until its owner sends last.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (sel_last) begin
            rr_ptr_d = next_id(sel_id, NREQ);
          end else begin
            state_d = LOCKED;
            owner_d = sel_id;
          end
        end
      end
      LOCKED: begin
        if (hs && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = next_id(owner_q, NREQ);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Multiplier operand register: operands zeroed on idle cycles, signedness flags hold.
  always_comb begin
    mul_a_d  = '0;
    mul_w_d  = '0;
    mul_as_d = mul_as_q;
    mul_ws_d = mul_ws_q;
    if (hs) begin
      mul_a_d  = sel_a;
      mul_w_d  = sel_w;
      mul_as_d = sel_as;
      mul_ws_d = sel_ws;
    end
  end

  // Tag pipe: the last stage lines up with the product on mul_q.
  always_comb begin
    tag_d[0].vld = hs;
    tag_d[0].id  = hs ? sel_id : '0;
    for (int k = 1; k <= MUL_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // Response register: route the product to its owner, keep the last product otherwise.
  always_comb begin
    rsp_valid_d = '0;
    rsp_q_d     = rsp_q_q;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid_d[i] = tag_q[MUL_LAT].vld && (tag_q[MUL_LAT].id == IDW'(i));
    end
    if (tag_q[MUL_LAT].vld) begin
      rsp_q_d = mul_q;
    end
  end

  // Busy while locked, while any beat is in the tag pipe, or while a response is out.
  always_comb begin
    busy = (state_q == LOCKED) | (|rsp_valid_q);
    for (int k = 0; k <= MUL_LAT; k++) begin
      busy = busy | tag_q[k].vld;
    end
  end

  // State registers; reset drops every in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      mul_a_q     <= '0;
      mul_w_q     <= '0;
      mul_as_q    <= 1'b0;
      mul_ws_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_q_q     <= '0;
      for (int k = 0; k <= MUL_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      mul_a_q     <= mul_a_d;
      mul_w_q     <= mul_w_d;
      mul_as_q    <= mul_as_d;
      mul_ws_q    <= mul_ws_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q_q     <= rsp_q_d;
      for (int k = 0; k <= MUL_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_w       = mul_w_q;
  assign mul_asigned = mul_as_q;
  assign mul_wsigned = mul_ws_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_q       = rsp_q_q;

endmodule
